synchronous_fifo: RTL and testbench
===================================

SYNCHRONOUS_FIFO -- requirements
Module: synchronous_fifo

Interface
REQ-001 The module SHALL use one clock and an asynchronous, active-high reset.
REQ-002 Parameter DEPTH SHALL default to 8 and set the number of storage entries (power of two, >=2).
REQ-003 Parameter WIDTH SHALL default to 3 and set the data width in bits.
REQ-004 Port clk SHALL be an input, 1 bit: sole clock, all state updates on rising edge.
REQ-005 Port reset_i SHALL be an input, 1 bit: asynchronous active-high reset.
REQ-006 Port wr_en_i SHALL be an input, 1 bit: write request.
REQ-007 Port data_i SHALL be an input, WIDTH bits: write data.
REQ-008 Port rd_en_i SHALL be an input, 1 bit: read request.
REQ-009 Port data_o SHALL be an output, WIDTH bits: registered read data.
REQ-010 Port full_o SHALL be an output, 1 bit: FIFO holds DEPTH entries.
REQ-011 Port empty_o SHALL be an output, 1 bit: FIFO holds 0 entries.

Function
REQ-012 Storage SHALL be a DEPTH x WIDTH array addressed by write and read pointers of log2(DEPTH)+1 bits (MSB = wrap bit).
REQ-013 A write SHALL be accepted on a rising edge iff wr_en_i=1 and full_o=0 (pre-edge value); data_i is stored at the write pointer, which then increments modulo 2*DEPTH.
REQ-014 A read SHALL be accepted on a rising edge iff rd_en_i=1 and empty_o=0 (pre-edge value); data_o loads the entry at the read pointer and the read pointer increments modulo 2*DEPTH.
REQ-015 Read latency SHALL be one cycle: data_o shows the oldest entry after the edge that accepts the read.
REQ-016 data_o SHALL hold its last value on every edge without an accepted read.
REQ-017 empty_o SHALL be combinational: 1 when the read and write pointers are equal, including the wrap bit.
REQ-018 full_o SHALL be combinational: 1 when the pointer address bits are equal and the wrap bits differ.
REQ-019 A write while full SHALL be dropped with no change to storage, pointers or flags, even if rd_en_i is also asserted.
REQ-020 A read while empty SHALL be ignored with no change to pointers, flags or data_o, even if wr_en_i is also asserted.
REQ-021 Simultaneous accepted read and write SHALL both occur in the same cycle, leaving occupancy unchanged.
REQ-022 Data SHALL leave in exact write order across pointer wrap-around, with no limit on wrap count.
REQ-023 full_o and empty_o SHALL never both be 1.

Reset
REQ-024 reset_i=1 SHALL immediately, independent of clk, clear both pointers to 0 and data_o to 0, giving empty_o=1 and full_o=0.
REQ-025 Storage array contents SHALL NOT be reset; they are unobservable until rewritten.
REQ-026 Reset asserted mid-operation SHALL discard all queued entries; the first write after release is the first read out.
REQ-027 While reset_i=1, write and read requests SHALL be ignored.

Verification
REQ-028 Reset with no other activity -> empty_o=1, full_o=0, data_o=0.
REQ-029 After reset, write 0..7 on 8 consecutive edges -> empty_o=0 after first write, full_o=1 only after the 8th.
REQ-030 Then read on 8 consecutive edges -> data_o=0,1,...,7 one per cycle, full_o=0 after first read, empty_o=1 after the 8th.
REQ-031 Repeat write 0..7 then read 8 to exercise wrap -> same sequence 0..7 and same flag timing.
REQ-032 When full, write 5 with wr_en_i=1, rd_en_i=0 -> contents unchanged, next 8 reads return the original data; when empty, rd_en_i=1 -> data_o holds last value, empty_o stays 1.
REQ-033 With 3 entries queued, assert wr_en_i and rd_en_i together for 4 cycles -> flags unchanged, outputs keep strict FIFO order; assert reset_i mid-sequence -> empty_o=1, data_o=0 at once.

Source files
------------

// File: rtl/synchronous_fifo.sv
// Synchronous FIFO, DEPTH x WIDTH, registered read data with one-cycle latency.
// Flags are combinational from wrap-bit pointers; writes when full and reads when empty are dropped.
module synchronous_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_ok;
  logic             rd_ok;

  assign empty_o = (wr_ptr == rd_ptr);
  assign full_o  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

  // Requests seen while reset is held must not disturb storage either.
  assign wr_ok = wr_en_i && !full_o && !reset_i;
  assign rd_ok = rd_en_i && !empty_o && !reset_i;

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      data_o <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_ok) begin
        data_o <= mem[rd_ptr[AW-1:0]];
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr[AW-1:0]] <= data_i;
    end
  end

endmodule

// File: tb/tb_synchronous_fifo.sv
// Bench for synchronous_fifo: directed vector table, corner sequences and
// randomized traffic checked against a queue-based reference model.
module tb_synchronous_fifo;

  localparam int DEPTH = 8;
  localparam int WIDTH = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             wr_en;
  logic [WIDTH-1:0] din;
  logic             rd_en;
  logic [WIDTH-1:0] dout;
  logic             full;
  logic             empty;

  int tests = 0;
  int fails = 0;

  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] mdout;

  typedef struct {
    bit               wr;
    logic [WIDTH-1:0] d;
    bit               rd;
    logic [WIDTH-1:0] exp_d;
    bit               exp_full;
    bit               exp_empty;
  } vec_t;

  vec_t vecs[18];

  synchronous_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk     (clk),
    .reset_i (rst),
    .wr_en_i (wr_en),
    .data_i  (din),
    .rd_en_i (rd_en),
    .data_o  (dout),
    .full_o  (full),
    .empty_o (empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".data"}, 32'(dout), 32'(mdout));
    chk({tag, ".full"}, 32'(full), 32'(q.size() == DEPTH));
    chk({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
  endtask

  // One clock cycle of traffic; the model decides acceptance from pre-edge occupancy.
  task automatic apply(input bit w, input logic [WIDTH-1:0] d, input bit r, input string tag);
    bit wa, ra;
    @(negedge clk);
    wr_en = w;
    din   = d;
    rd_en = r;
    wa = w && (q.size() < DEPTH);
    ra = r && (q.size() > 0);
    @(posedge clk);
    #1;
    if (ra) mdout = q.pop_front();
    if (wa) q.push_back(d);
    chk_model(tag);
  endtask

  // Reset asserted between edges must act at once; requests during reset are ignored.
  task automatic pulse_reset(input string tag);
    @(negedge clk);
    #2;
    rst   = 1'b1;
    wr_en = 1'b1;
    rd_en = 1'b1;
    din   = 3'd5;
    #1;
    q.delete();
    mdout = '0;
    chk_model({tag, ".async"});
    @(posedge clk);
    #1;
    chk_model({tag, ".held"});
    @(negedge clk);
    rst   = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  initial begin
    // 8 writes, overflow write, 8 reads, underflow read.
    for (int i = 0; i < 8; i++)
      vecs[i] = '{wr: 1'b1, d: 3'(i), rd: 1'b0, exp_d: 3'd0,
                  exp_full: (i == 7), exp_empty: 1'b0};
    vecs[8] = '{wr: 1'b1, d: 3'd5, rd: 1'b0, exp_d: 3'd0, exp_full: 1'b1, exp_empty: 1'b0};
    for (int i = 0; i < 8; i++)
      vecs[9+i] = '{wr: 1'b0, d: 3'd0, rd: 1'b1, exp_d: 3'(i),
                    exp_full: 1'b0, exp_empty: (i == 7)};
    vecs[17] = '{wr: 1'b0, d: 3'd0, rd: 1'b1, exp_d: 3'd7, exp_full: 1'b0, exp_empty: 1'b1};

    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; din = '0;
    mdout = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.data", 32'(dout), 32'd0);
    chk("reset.full", 32'(full), 32'd0);
    chk("reset.empty", 32'(empty), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // Second pass runs the pointers through wrap-around; data_o starts at 7 then.
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 18; i++) begin
        apply(vecs[i].wr, vecs[i].d, vecs[i].rd, "vec");
        if (pass == 1 && i < 9)
          chk($sformatf("vec%0d_%0d.data", pass, i), 32'(dout), 32'd7);
        else
          chk($sformatf("vec%0d_%0d.data", pass, i), 32'(dout), 32'(vecs[i].exp_d));
        chk($sformatf("vec%0d_%0d.full", pass, i), 32'(full), 32'(vecs[i].exp_full));
        chk($sformatf("vec%0d_%0d.empty", pass, i), 32'(empty), 32'(vecs[i].exp_empty));
      end
    end

    // Full with simultaneous read: the read is taken, the write is dropped.
    for (int i = 0; i < 8; i++) apply(1'b1, 3'(7 - i), 1'b0, "fill");
    apply(1'b1, 3'd2, 1'b1, "full_rw");
    chk("full_rw.data", 32'(dout), 32'd7);
    chk("full_rw.full", 32'(full), 32'd0);
    for (int i = 0; i < 7; i++) apply(1'b0, 3'd0, 1'b1, "drain");
    chk("drain.last", 32'(dout), 32'd0);
    // Empty with simultaneous write: read ignored, write taken.
    apply(1'b1, 3'd3, 1'b1, "empty_rw");
    chk("empty_rw.data", 32'(dout), 32'd0);
    chk("empty_rw.empty", 32'(empty), 32'd0);
    apply(1'b0, 3'd0, 1'b1, "empty_rw_rd");
    chk("empty_rw_rd.data", 32'(dout), 32'd3);

    // Three queued, then four cycles of concurrent read and write.
    for (int i = 1; i <= 3; i++) apply(1'b1, 3'(i), 1'b0, "pre3");
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, 3'(4 + i), 1'b1, "rw");
      chk($sformatf("rw%0d.data", i), 32'(dout), 32'(i + 1));
      chk($sformatf("rw%0d.flags", i), 32'({full, empty}), 32'd0);
    end
    pulse_reset("mid_rst");
    chk("mid_rst.empty", 32'(empty), 32'd1);
    chk("mid_rst.data", 32'(dout), 32'd0);
    apply(1'b1, 3'd6, 1'b0, "post_rst_wr");
    apply(1'b0, 3'd0, 1'b1, "post_rst_rd");
    chk("post_rst.first", 32'(dout), 32'd6);

    // Randomized traffic in phases biased toward filling and draining.
    for (int n = 0; n < 3000; n++) begin
      int phase;
      bit w, r;
      phase = (n / 150) % 3;
      case (phase)
        0:       begin w = ($urandom_range(0, 9) < 8); r = ($urandom_range(0, 9) < 3); end
        1:       begin w = ($urandom_range(0, 9) < 3); r = ($urandom_range(0, 9) < 8); end
        default: begin w = $urandom_range(0, 1) != 0; r = $urandom_range(0, 1) != 0; end
      endcase
      if ($urandom_range(0, 399) == 0) pulse_reset("rnd_rst");
      else apply(w, 3'($urandom), r, "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, limit 2000000 reached");
    $fatal(1);
  end

endmodule
